blink_sequencer: RTL and testbench
==================================

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the prescaler counter and the period input.
REQ-002 SHALL have parameter BURST_N, default 4, meaning the number of pulses emitted in burst mode (1..15).
REQ-003 SHALL have port Clock_IN, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port Mode_IN, input, 2 bits: requested mode (00 OFF, 01 BLINK, 10 ALTERNATE, 11 BURST).
REQ-006 SHALL have port Period_IN, input, CNT_W bits: half-period of the blink, in Clock_IN cycles.
REQ-007 SHALL have port Mode_Valid, input, 1 bit: a mode/period request is present.
REQ-008 SHALL have port Mode_Ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port OUT_High, output, 1 bit: LED drive A.
REQ-010 SHALL have port OUT_low, output, 1 bit: LED drive B.
REQ-011 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement the states IDLE, BLINK, ALT and BURST.
REQ-013 SHALL accept a request on a rising edge where Mode_Valid=1 and Mode_Ready=1, latching Mode_IN and Period_IN.
REQ-014 SHALL drive Mode_Ready=1 in IDLE, BLINK and ALT, and Mode_Ready=0 in BURST.
REQ-015 SHALL treat a latched Period_IN of 0 as 1.
REQ-016 SHALL run a prescaler blink_count from 0 to period-1 while not in IDLE, asserting an internal tick on the cycle it equals period-1 and wrapping to 0.
REQ-017 SHALL, on accepting a request, clear blink_count and the phase bit to 0 and enter the new state on the next cycle: OFF->IDLE, BLINK->BLINK, ALTERNATE->ALT, BURST->BURST.
REQ-018 SHALL toggle the phase bit on each tick.
REQ-019 In IDLE: OUT_High=0, OUT_low=0, and blink_count held at 0.
REQ-020 In BLINK: OUT_High=phase and OUT_low=phase.
REQ-021 In ALT: OUT_High=phase and OUT_low=~phase.
REQ-022 In BURST: OUT_High=phase, OUT_low=0; a pulse counter increments on each 1->0 phase transition, and after BURST_N pulses the block returns to IDLE with outputs 0 on the next cycle.
REQ-023 SHALL ignore Mode_Valid while in BURST; no request is lost, because Mode_Ready=0 holds it off.
REQ-024 On a new request accepted mid-period, the new period takes effect immediately and no stale tick occurs.
REQ-025 When a tick and an accepted request fall on the same edge, the request SHALL win: the counter and phase are cleared, not toggled.
REQ-026 The counter width SHALL be exactly CNT_W, with a comparison against period-1 and no overflow; Period_IN=2^CNT_W-1 SHALL be legal.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs except Mode_Ready from state.

Reset
REQ-028 Reset=1 SHALL immediately, without a clock, force state=IDLE, blink_count=0, phase=0, pulse counter=0, latched period=1, OUT_High=0, OUT_low=0, Busy=0 and Mode_Ready=1.
REQ-029 Reset asserted mid-BURST or mid-period SHALL abort the operation; after release, the block stays in IDLE until a new request.
REQ-030 Requests SHALL be accepted from the first rising edge after Reset deasserts.

Verification
REQ-031 Apply BLINK with Period_IN=3 -> OUT_High=OUT_low, toggling every 3 cycles (6-cycle period) starting at 0.
REQ-032 Apply ALTERNATE with Period_IN=2 -> OUT_low=~OUT_High at all times, toggling every 2 cycles.
REQ-033 Apply BURST with Period_IN=1 and BURST_N=4 -> exactly 4 high pulses on OUT_High, Mode_Ready=0 throughout, then IDLE with Busy=0 and Mode_Ready=1.
REQ-034 Apply BLINK with Period_IN=5, then at count 4 (tick edge) request ALT with Period_IN=2 -> phase=0, count=0, and the first ALT toggle 2 cycles later.
REQ-035 Pulse Reset asynchronously mid-BURST between clock edges -> outputs 0 before the next edge, and IDLE after release.
REQ-036 Apply BLINK with Period_IN=0 -> behaves as Period_IN=1, toggling every cycle.

Source files
------------

// File: rtl/blink_sequencer.sv
// LED blink sequencer: OFF / BLINK / ALTERNATE / BURST patterns driven by a
// programmable half-period prescaler, with a valid/ready request interface.
module blink_sequencer #(
   parameter int CNT_W   = 32,
   parameter int BURST_N = 4
) (
   input  logic             Clock_IN,
   input  logic             Reset,
   input  logic [1:0]       Mode_IN,
   input  logic [CNT_W-1:0] Period_IN,
   input  logic             Mode_Valid,
   output logic             Mode_Ready,
   output logic             OUT_High,
   output logic             OUT_low,
   output logic             Busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_BLINK = 2'b01,
      S_ALT   = 2'b10,
      S_BURST = 2'b11
   } state_t;

   localparam logic [3:0]       LP_LAST_PULSE = 4'(BURST_N - 1);
   localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_period;
   logic             r_phase;
   logic [3:0]       r_pulse;
   logic             r_high;
   logic             r_low;
   logic             r_busy;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W-1:0] w_period_nxt;
   logic             w_phase_nxt;
   logic [3:0]       w_pulse_nxt;
   logic             w_high_nxt;
   logic             w_low_nxt;
   logic             w_busy_nxt;
   logic             w_accept;
   logic             w_tick;
   logic [CNT_W-1:0] w_period_in;

   assign Mode_Ready = (r_state != S_BURST);
   assign w_accept   = Mode_Valid && Mode_Ready;
   assign OUT_High   = r_high;
   assign OUT_low    = r_low;
   assign Busy       = r_busy;

   // Period is never 0, so period-1 cannot underflow and all-ones is usable.
   assign w_period_in = (Period_IN == '0) ? LP_ONE : Period_IN;
   assign w_tick      = (r_state != S_IDLE) && (r_count == (r_period - LP_ONE));

   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_period_nxt = r_period;
      w_phase_nxt  = r_phase;
      w_pulse_nxt  = r_pulse;

      if (w_accept) begin
         // An accepted request overrides any tick on the same edge.
         w_period_nxt = w_period_in;
         w_count_nxt  = '0;
         w_phase_nxt  = 1'b0;
         w_pulse_nxt  = '0;
         case (Mode_IN)
            2'b01:   w_state_nxt = S_BLINK;
            2'b10:   w_state_nxt = S_ALT;
            2'b11:   w_state_nxt = S_BURST;
            default: w_state_nxt = S_IDLE;
         endcase
      end else if (r_state == S_IDLE) begin
         w_count_nxt = '0;
         w_phase_nxt = 1'b0;
      end else if (w_tick) begin
         w_count_nxt = '0;
         w_phase_nxt = ~r_phase;
         if ((r_state == S_BURST) && r_phase) begin
            if (r_pulse == LP_LAST_PULSE) begin
               w_state_nxt = S_IDLE;
               w_phase_nxt = 1'b0;
               w_pulse_nxt = '0;
            end else begin
               w_pulse_nxt = r_pulse + 4'd1;
            end
         end
      end else begin
         w_count_nxt = r_count + LP_ONE;
      end
   end

   // Outputs are registered from next-state values so they line up with state.
   always_comb begin
      w_high_nxt = 1'b0;
      w_low_nxt  = 1'b0;
      case (w_state_nxt)
         S_BLINK: begin
            w_high_nxt = w_phase_nxt;
            w_low_nxt  = w_phase_nxt;
         end
         S_ALT: begin
            w_high_nxt = w_phase_nxt;
            w_low_nxt  = ~w_phase_nxt;
         end
         S_BURST: begin
            w_high_nxt = w_phase_nxt;
            w_low_nxt  = 1'b0;
         end
         default: begin
            w_high_nxt = 1'b0;
            w_low_nxt  = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge Clock_IN or posedge Reset) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_count  <= '0;
         r_period <= LP_ONE;
         r_phase  <= 1'b0;
         r_pulse  <= '0;
         r_high   <= 1'b0;
         r_low    <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_period <= w_period_nxt;
         r_phase  <= w_phase_nxt;
         r_pulse  <= w_pulse_nxt;
         r_high   <= w_high_nxt;
         r_low    <= w_low_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer: a per-cycle vector table for BLINK/ALT
// plus hand-written sequences for burst, tick/request collision and reset.
module tb_blink_sequencer;

   typedef struct {
      logic        valid;
      logic [1:0]  mode;
      logic [31:0] period;
      logic        h;
      logic        l;
      logic        b;
      logic        r;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [1:0]  mode;
   logic [31:0] period;
   logic        valid;
   logic        ready;
   logic        out_h;
   logic        out_l;
   logic        busy;

   int unsigned n_vec;
   int unsigned n_err;

   vec_t tbl[20];

   blink_sequencer #(
      .CNT_W   (32),
      .BURST_N (4)
   ) dut (
      .Clock_IN   (clk),
      .Reset      (rst),
      .Mode_IN    (mode),
      .Period_IN  (period),
      .Mode_Valid (valid),
      .Mode_Ready (ready),
      .OUT_High   (out_h),
      .OUT_low    (out_l),
      .Busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] p);
      valid  = v;
      mode   = m;
      period = p;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic h, input logic l,
                        input logic b, input logic r);
      n_vec++;
      if (out_h !== h || out_l !== l || busy !== b || ready !== r) begin
         n_err++;
         $display("FAIL %s: got H=%b L=%b Busy=%b Ready=%b, expected H=%b L=%b Busy=%b Ready=%b",
                  name, out_h, out_l, busy, ready, h, l, b, r);
      end
   endtask

   task automatic check_val(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      int pulses;
      logic prev_h;

      n_vec = 0;
      n_err = 0;

      // BLINK period 3: six-cycle period starting low, then ALT period 2, then OFF.
      tbl[0]  = '{1'b1, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b0, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[2]  = '{1'b0, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[3]  = '{1'b0, 2'b01, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 2'b01, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 2'b01, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 2'b01, 32'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 2'b01, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 2'b10, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 2'b10, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[12] = '{1'b0, 2'b10, 32'd2, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 2'b10, 32'd2, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 2'b10, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 2'b10, 32'd2, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 2'b10, 32'd2, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[17] = '{1'b1, 2'b00, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[18] = '{1'b0, 2'b00, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 2'b11, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      drive(1'b0, 2'b00, 32'd0);
      #1;
      check("reset_initial", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      step();
      check("reset_held", 1'b0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;

      // Vector 0 is accepted on the first edge after release.
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].valid, tbl[i].mode, tbl[i].period);
         step();
         check($sformatf("table[%0d]", i), tbl[i].h, tbl[i].l, tbl[i].b, tbl[i].r);
      end

      // Maximum period is legal: no early toggle.
      drive(1'b1, 2'b01, 32'hFFFF_FFFF);
      step();
      check("maxper_accept", 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 2'b01, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("maxper_hold[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b1);
      end
      drive(1'b1, 2'b00, 32'd0);
      step();
      check("maxper_off", 1'b0, 1'b0, 1'b0, 1'b1);

      // BURST period 1: four one-cycle pulses, requests held off throughout.
      drive(1'b1, 2'b11, 32'd1);
      step();
      check("burst_accept", 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 2'b01, 32'd7);
      pulses = 0;
      prev_h = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (out_h && !prev_h) pulses++;
         prev_h = out_h;
         if (i < 8)
            check($sformatf("burst[%0d]", i), logic'(i % 2), 1'b0, 1'b1, 1'b0);
         else
            check("burst_done", 1'b0, 1'b0, 1'b0, 1'b1);
      end
      drive(1'b0, 2'b01, 32'd7);
      step();
      check("burst_ignored_req", 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("burst_pulses", pulses, 4);

      // Request landing on a BLINK tick edge wins over the toggle.
      drive(1'b1, 2'b01, 32'd5);
      step();
      check("coll_blink", 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 2'b01, 32'd5);
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("coll_cnt[%0d]", i), 1'b0, 1'b0, 1'b1, 1'b1);
      end
      drive(1'b1, 2'b10, 32'd2);
      step();
      check("coll_alt_accept", 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 2'b10, 32'd2);
      step();
      check("coll_alt_c1", 1'b0, 1'b1, 1'b1, 1'b1);
      step();
      check("coll_alt_toggle", 1'b1, 1'b0, 1'b1, 1'b1);

      // Asynchronous reset between edges during a BURST high phase.
      drive(1'b1, 2'b11, 32'd3);
      step();
      check("rst_burst_accept", 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 2'b00, 32'd0);
      step();
      step();
      step();
      check("rst_burst_high", 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async", 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      rst = 1'b0;
      step();
      check("rst_idle_1", 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("rst_idle_2", 1'b0, 1'b0, 1'b0, 1'b1);

      // Period 0 behaves as period 1.
      drive(1'b1, 2'b01, 32'd0);
      step();
      check("per0_accept", 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 2'b01, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("per0[%0d]", i), logic'(i % 2), logic'(i % 2), 1'b1, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
